// File: rtl/sram_array_1p_init.sv
// Single-port SRAM array with per-segment write mask, registered read data and
// a post-reset zeroing sweep enabled by the SRAM_ZERO_INIT_EN macro.
module sram_array_1p_init #(
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 24,
  parameter int MASK_SEG = 2,
  localparam int ADDR_W  = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rw_valid,
  output logic                rw_ready,
  input  logic [ADDR_W-1:0]   rw_addr,
  input  logic                rw_wmode,
  input  logic [MASK_SEG-1:0] rw_wmask,
  input  logic [WIDTH-1:0]    rw_wdata,
  output logic [WIDTH-1:0]    rw_rdata,
  output logic                rdata_valid,
  output logic                init_done
);

  localparam int SEG_W = WIDTH / MASK_SEG;

  // Handshake: a request transfers on a rising edge where rw_valid && rw_ready;
  // the requester holds its inputs stable until then, nothing is queued here.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               in_range;
  logic               accept;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [MASK_SEG-1:0] mem_wmask;

`ifdef SRAM_ZERO_INIT_EN
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] sweep;
`endif

  // Gating with reset keeps the outputs low and ignores requests during reset.
  assign rw_ready  = (state == ST_READY) && !reset;
  assign init_done = rw_ready;
  assign accept    = rw_valid && rw_ready;
  assign in_range  = ({1'b0, rw_addr} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rw_addr;
    mem_wdata = rw_wdata;
    mem_wmask = rw_wmask;
`ifdef SRAM_ZERO_INIT_EN
    if (!reset && state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep;
      mem_wdata = '0;
      mem_wmask = '1;
    end
`endif
    if (accept && rw_wmode && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (mem_wmask[i]) begin
          mem[mem_waddr][i*SEG_W +: SEG_W] <= mem_wdata[i*SEG_W +: SEG_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      rdata_valid <= 1'b0;
      rw_rdata    <= '0;
`ifdef SRAM_ZERO_INIT_EN
      sweep       <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        ST_INIT: begin
`ifdef SRAM_ZERO_INIT_EN
          sweep <= sweep + 1'b1;
          if (sweep == SWEEP_LAST) begin
            state <= ST_READY;
          end
`else
          state <= ST_READY;
`endif
        end
        default: begin
          // Out-of-range reads complete normally but return zero.
          if (accept && !rw_wmode) begin
            rw_rdata    <= in_range ? mem[rw_addr] : '0;
            rdata_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_array_1p_init.sv
// Directed bench for sram_array_1p_init: a DEPTH=256 array plus a DEPTH=200
// array for out-of-range addresses, read data checked through expected queues.
module tb_sram_array_1p_init;

  localparam int W       = 24;
  localparam int B_DEPTH = 200;
`ifdef SRAM_ZERO_INIT_EN
  localparam int INIT_CYC = 256;
`else
  localparam int INIT_CYC = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid;
  logic [7:0]   rw_addr;
  logic         rw_wmode;
  logic [1:0]   rw_wmask;
  logic [W-1:0] rw_wdata;
  logic         a_ready, a_rdata_valid, a_init_done;
  logic [W-1:0] a_rdata;
  logic         b_ready, b_rdata_valid, b_init_done;
  logic [W-1:0] b_rdata;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] model_a [256];
  logic [W-1:0] model_b [256];
  logic [W-1:0] last_a_exp;
  int compared = 0;
  int mismatched = 0;

  sram_array_1p_init #(.DEPTH(256), .WIDTH(24), .MASK_SEG(2)) dut_a (
    .clock(clk), .reset(reset), .rw_valid(a_valid), .rw_ready(a_ready),
    .rw_addr(rw_addr), .rw_wmode(rw_wmode), .rw_wmask(rw_wmask),
    .rw_wdata(rw_wdata), .rw_rdata(a_rdata), .rdata_valid(a_rdata_valid),
    .init_done(a_init_done)
  );

  sram_array_1p_init #(.DEPTH(B_DEPTH), .WIDTH(24), .MASK_SEG(2)) dut_b (
    .clock(clk), .reset(reset), .rw_valid(b_valid), .rw_ready(b_ready),
    .rw_addr(rw_addr), .rw_wmode(rw_wmode), .rw_wmask(rw_wmask),
    .rw_wdata(rw_wdata), .rw_rdata(b_rdata), .rdata_valid(b_rdata_valid),
    .init_done(b_init_done)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%06h expected 0x%06h", tag, obs, want);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [1:0] m,
                                         input logic [W-1:0] d);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < 2; i++) if (m[i]) r[i*12 +: 12] = d[i*12 +: 12];
    return r;
  endfunction

  // Driver: one accepted request per call (caller guarantees ready).
  task automatic req(input bit sel, input bit w, input logic [7:0] a,
                     input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] want;
    rw_addr = a; rw_wmode = w; rw_wmask = m; rw_wdata = d;
    a_valid = !sel; b_valid = sel;
    if (w) begin
      if (!sel) model_a[a] = merge(model_a[a], m, d);
      else if (int'(a) < B_DEPTH) model_b[a] = merge(model_b[a], m, d);
    end else if (!sel) begin
      want = model_a[a];
      last_a_exp = want;
      exp_q.push_back(want);
    end else begin
      want = (int'(a) < B_DEPTH) ? model_b[a] : '0;
      exp_b_q.push_back(want);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!a_ready && cyc < 400);
    check(tag, 24'(cyc), 24'(INIT_CYC));
    check({tag, "_done"}, 24'(a_init_done), 24'd1);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (a_rdata_valid) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL a_spurious_valid: observed rdata_valid=1 expected no pulse");
      end
      if (exp_q.size() != 0) check("a_rdata", a_rdata, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_rdata_valid) begin
      compared++;
      assert (exp_b_q.size() != 0) else begin
        mismatched++;
        $error("FAIL b_spurious_valid: observed rdata_valid=1 expected no pulse");
      end
      if (exp_b_q.size() != 0) check("b_rdata", b_rdata, exp_b_q.pop_front());
    end
  end

  initial begin
    logic [7:0]   a;
    logic [1:0]   m;
    logic [W-1:0] d;
    for (int i = 0; i < 256; i++) begin model_a[i] = '0; model_b[i] = '0; end
    last_a_exp = '0;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    rw_addr = '0; rw_wmode = 1'b0; rw_wmask = '0; rw_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 24'(a_ready), 24'd0);
    check("rst_init_done", 24'(a_init_done), 24'd0);
    check("rst_rdata_valid", 24'(a_rdata_valid), 24'd0);
    check("rst_rdata", a_rdata, 24'd0);

    // Request held from reset release; it must stall until the array is ready.
    a_valid = 1'b1; rw_wmask = 2'b11; rw_wdata = 24'h0A5A5A;
`ifdef SRAM_ZERO_INIT_EN
    rw_wmode = 1'b0; rw_addr = 8'h10;
`else
    rw_wmode = 1'b1; rw_addr = 8'h00;
`endif
    reset = 1'b0;
    wait_ready("ready_latency");
`ifdef SRAM_ZERO_INIT_EN
    req(0, 0, 8'h10, 2'b11, 24'h0);
`else
    req(0, 1, 8'h00, 2'b11, 24'h0A5A5A);
    req(0, 0, 8'h00, 2'b00, 24'h0);
`endif
    idle(2);

    // Masked writes and read-after-write
    req(0, 1, 8'h05, 2'b11, 24'hABCDEF);
    req(0, 1, 8'h05, 2'b01, 24'h123456);
    req(0, 0, 8'h05, 2'b00, 24'h0);
    idle(1);
    req(0, 0, 8'h05, 2'b00, 24'h0);
    req(0, 1, 8'h05, 2'b11, 24'hFFFFFF);
    idle(3);
    check("hold_rdata", a_rdata, last_a_exp);
    check("hold_valid", 24'(a_rdata_valid), 24'd0);
    req(0, 0, 8'h05, 2'b00, 24'h0);
    req(0, 1, 8'h05, 2'b00, 24'h000000);
    req(0, 0, 8'h05, 2'b00, 24'h0);
    req(0, 1, 8'h05, 2'b10, 24'h777777);
    req(0, 0, 8'h05, 2'b00, 24'h0);

    // Top address and out-of-range addresses on the smaller array
    req(0, 1, 8'hFF, 2'b11, 24'h111111);
    req(0, 0, 8'hFF, 2'b00, 24'h0);
    req(1, 1, 8'hFF, 2'b11, 24'h111111);
    req(1, 0, 8'hFF, 2'b00, 24'h0);
    req(1, 1, 8'hC7, 2'b11, 24'h2468AC);
    req(1, 0, 8'hC7, 2'b00, 24'h0);
    req(1, 1, 8'hC8, 2'b11, 24'h999999);
    req(1, 0, 8'hC8, 2'b00, 24'h0);
    idle(2);

    // Randomised traffic over a small, fully written window
    for (int i = 0; i < 16; i++) req(0, 1, 8'(8'h40 + i), 2'b11, 24'($urandom()));
    for (int i = 0; i < 40; i++) begin
      a = 8'(8'h40 + $urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      d = 24'($urandom());
      req(0, 1'($urandom_range(0, 1)), a, m, d);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Reset in READY (with a request presented under reset) and, with the
    // sweep, a second reset part-way through initialisation.
    req(0, 1, 8'h20, 2'b11, 24'h5A5A5A);
    idle(2);
    reset = 1'b1;
    a_valid = 1'b1; rw_wmode = 1'b1; rw_addr = 8'h20; rw_wmask = 2'b11; rw_wdata = 24'hDEAD00;
    @(posedge clk); #1;
    check("reset_ready", 24'(a_ready), 24'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
`ifdef SRAM_ZERO_INIT_EN
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_ready", 24'(a_ready), 24'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin model_a[i] = '0; model_b[i] = '0; end
`endif
    reset = 1'b0;
    wait_ready("ready_after_reset");
    req(0, 0, 8'h20, 2'b00, 24'h0);
    req(1, 0, 8'hC7, 2'b00, 24'h0);
    idle(3);

    compared++;
    assert (exp_q.size() == 0 && exp_b_q.size() == 0) else begin
      mismatched++;
      $error("FAIL drain: observed %0d/%0d reads outstanding expected 0/0", exp_q.size(), exp_b_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_array_1p_init.md
SRAM_ARRAY_1P_INIT -- requirements
Module: sram_array_1p_init

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of words (>=2, any integer).
REQ-002 SHALL have parameter WIDTH, default 24, bits per word.
REQ-003 SHALL have parameter MASK_SEG, default 2, write-mask segments; WIDTH divisible by MASK_SEG; segment width SEG_W = WIDTH/MASK_SEG.
REQ-004 SHALL derive localparam ADDR_W = max(1, clog2(DEPTH)).
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rw_valid  input  1  request present.
REQ-008 SHALL have port rw_ready  output  1  array accepts requests this cycle.
REQ-009 SHALL have port rw_addr  input  ADDR_W  word address.
REQ-010 SHALL have port rw_wmode  input  1  1 = write, 0 = read.
REQ-011 SHALL have port rw_wmask  input  MASK_SEG  per-segment write enable; bit i covers bits [i*SEG_W +: SEG_W].
REQ-012 SHALL have port rw_wdata  input  WIDTH  write data.
REQ-013 SHALL have port rw_rdata  output  WIDTH  registered read data.
REQ-014 SHALL have port rdata_valid  output  1  one-cycle pulse: rw_rdata updated this cycle.
REQ-015 SHALL have port init_done  output  1  array initialised and in service.

Function
REQ-016 Request SHALL be accepted only on a rising edge where rw_valid && rw_ready; otherwise all request inputs are ignored.
REQ-017 Accepted write SHALL update only segments whose rw_wmask bit is 1; all-zero mask updates nothing.
REQ-018 Accepted read SHALL load rw_rdata with the word at rw_addr on the same edge (1-cycle latency) and assert rdata_valid for exactly the following cycle.
REQ-019 rw_rdata SHALL hold its value until the next accepted read; later writes, including to the same address, do not alter it.
REQ-020 Read accepted the cycle after a write to the same address SHALL return the newly written segments.
REQ-021 Out-of-range address (rw_addr >= DEPTH) SHALL be accepted: write discarded, read returns all-zero with normal rdata_valid pulse.
REQ-022 State machine SHALL have states INIT and READY; rw_ready = init_done = (state == READY).
REQ-023 INIT SHALL write all-zero to address 0, 1, ... DEPTH-1, one word per cycle, using an internal sweep counter; transition to READY on the cycle after address DEPTH-1 is written (DEPTH cycles in INIT).
REQ-024 rw_valid asserted during INIT SHALL stall (not accepted, not lost by the array; requester holds it).
REQ-025 READY SHALL be held until reset.

Reset
REQ-026 While reset is high: state = INIT, sweep counter = 0, rw_ready = 0, init_done = 0, rdata_valid = 0, rw_rdata = 0.
REQ-027 Reset asserted mid-INIT SHALL restart the sweep from address 0; reset in READY SHALL re-enter INIT and re-clear the array.
REQ-028 Request presented in the same cycle reset is high SHALL be ignored.

Configuration
REQ-029 Macro SRAM_ZERO_INIT_EN SHALL control the initialisation sweep.
REQ-030 With SRAM_ZERO_INIT_EN defined: behaviour per REQ-023/REQ-027; first request accepted DEPTH cycles after reset deasserts.
REQ-031 Without SRAM_ZERO_INIT_EN: no sweep counter; state goes INIT->READY in the first cycle after reset deasserts; array contents undefined (random under RANDOMIZE_MEM_INIT); reset does not modify contents.

Verification (DEPTH=256, WIDTH=24, MASK_SEG=2, SRAM_ZERO_INIT_EN defined unless stated)
REQ-032 Release reset, hold rw_valid=1 read addr 0x10 -> rw_ready rises exactly 256 cycles later; read accepted that edge; next cycle rdata_valid=1, rw_rdata=0x000000.
REQ-033 Write 0xABCDEF mask 2'b11 addr 0x05, then write 0x123456 mask 2'b01 addr 0x05, read 0x05 -> rw_rdata=0xABC456.
REQ-034 Read 0x05 (0xABC456), then write 0xFFFFFF mask 2'b11 to 0x05 with no further reads -> rw_rdata stays 0xABC456, rdata_valid low after its single pulse.
REQ-035 Write 0x111111 to 0xFF, read 0xFF next cycle -> 0x111111; read addr 0xFF with DEPTH=200 after write -> 0x000000.
REQ-036 Assert reset at sweep address 100 for one cycle, then release -> rw_ready rises 256 cycles after release; data previously written reads 0x000000.
REQ-037 Without SRAM_ZERO_INIT_EN: release reset -> rw_ready=1 one cycle later; write/read 0x0A5A5A at 0x00 returns 0x0A5A5A.
